// File: rtl/bound_flash_multi_pkg.sv
// Shared types and helpers for the bounded-flash lamp sequencer.
// Holds the state encoding, lamp position mapping and parameter checks.
package bound_flash_pkg;

  typedef enum logic [3:0] {
    IDLE,
    UP1,
    DN1,
    UP2,
    DNK,
    DN2,
    UP3,
    DN3,
    BLINK
  } state_t;

  function automatic logic [5:0] pos_map(
    input logic [5:0] idx,
    input logic       mirror,
    input int         n
  );
    return mirror ? 6'(n - 1 - int'(idx)) : idx;
  endfunction

  function automatic bit params_ok(
    input int n,
    input int b1,
    input int b2,
    input int div
  );
    return (n >= 4) && (n <= 64) && (b1 > 0) &&
           (b1 < b2) && (b2 < n - 1) && (div >= 1);
  endfunction

endpackage

// File: rtl/bound_flash_multi_if.sv
// Lamp-bar handshake bundle: start/mirror requests in, lamps and
// run status out.
interface bound_flash_multi_if #(
  parameter int N = 16
);
  logic         flick;
  logic         mirror;
  logic [N-1:0] lamp;
  logic         busy;
  logic         done;

  modport master (
    output flick, mirror,
    input  lamp, busy, done
  );

  modport slave (
    input  flick, mirror,
    output lamp, busy, done
  );
endinterface

// File: rtl/bound_flash_multi_bf_step_div.sv
// Step prescaler: one-clock strobe every DIV enabled clocks.
module bf_step_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign step = en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (en)
      r_cnt <= step ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/bound_flash_multi.sv
// N-lamp bounded fill/clear sequencer with kickback, mirroring,
// step prescaler and a final all-lamp blink phase.
module bound_flash_multi
  import bound_flash_pkg::*;
#(
  parameter int N      = 16,
  parameter int B1     = 5,
  parameter int B2     = 10,
  parameter int DIV    = 1,
  parameter int BLINKS = 1
) (
  input logic           clk,
  input logic           rst,
  bound_flash_multi_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(2 * BLINKS + 2);
  localparam logic [IW-1:0] I_B1  = IW'(B1);
  localparam logic [IW-1:0] I_B2  = IW'(B2);
  localparam logic [IW-1:0] I_TOP = IW'(N - 1);
  localparam logic [BW-1:0] B_LAST =
    (BLINKS > 0) ? BW'(2 * BLINKS - 1) : '0;

  if (!params_ok(N, B1, B2, DIV)) begin : g_bad_params
    $error("bound_flash_multi: illegal N/B1/B2/DIV");
  end

  state_t        r_state, w_state;
  logic [IW-1:0] r_idx,   w_idx;
  logic [N-1:0]  r_lamp,  w_lamp;
  logic          r_busy,  w_busy;
  logic          r_done,  w_done;
  logic          r_mir,   w_mir;
  logic [BW-1:0] r_bcnt,  w_bcnt;

  logic          w_step;
  logic          w_start;
  logic          w_up;
  logic          w_dn;
  logic          w_fin;
  logic [IW-1:0] w_pos;
  logic [IW-1:0] w_inc;
  logic [IW-1:0] w_dec;

  assign w_start = (r_state == IDLE) && bus.flick;
  assign w_pos   = IW'(pos_map(6'(r_idx), r_mir, N));
  assign w_inc   = r_idx + IW'(1);
  assign w_dec   = r_idx - IW'(1);
  assign w_up    = (r_state == UP1) || (r_state == UP2) ||
                   (r_state == UP3);
  assign w_dn    = (r_state == DN1) || (r_state == DNK) ||
                   (r_state == DN2) || (r_state == DN3);

  bf_step_div #(
    .DIV(DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .clr (w_start),
    .en  (r_busy),
    .step(w_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_lamp  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mir   <= 1'b0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_lamp  <= w_lamp;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_mir   <= w_mir;
      r_bcnt  <= w_bcnt;
    end
  end

  // End tests compare before stepping, so idx never wraps at 0 or N-1.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_lamp  = r_lamp;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_mir   = r_mir;
    w_bcnt  = r_bcnt;
    w_fin   = 1'b0;

    if (w_step && w_up) w_lamp[w_pos] = 1'b1;
    if (w_step && w_dn) w_lamp[w_pos] = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.flick) begin
          w_state = UP1;
          w_idx   = '0;
          w_busy  = 1'b1;
          w_mir   = bus.mirror;
          w_bcnt  = '0;
        end
      end
      UP1: if (w_step) begin
        if (r_idx == I_B1) w_state = DN1;
        else               w_idx   = w_inc;
      end
      DN1: if (w_step) begin
        if (r_idx == '0) w_state = UP2;
        else             w_idx   = w_dec;
      end
      UP2: if (w_step) begin
        if (r_idx == I_B2) w_state = bus.flick ? DNK : DN2;
        else               w_idx   = w_inc;
      end
      DNK: if (w_step) begin
        if (r_idx == '0) w_state = UP2;
        else             w_idx   = w_dec;
      end
      DN2: if (w_step) begin
        if (r_idx == I_B1) w_state = UP3;
        else               w_idx   = w_dec;
      end
      UP3: if (w_step) begin
        if (r_idx == I_TOP) w_state = DN3;
        else                w_idx   = w_inc;
      end
      DN3: if (w_step) begin
        if (r_idx == '0) begin
          if (BLINKS > 0) begin
            w_state = BLINK;
            w_bcnt  = '0;
          end else begin
            w_fin = 1'b1;
          end
        end else begin
          w_idx = w_dec;
        end
      end
      BLINK: if (w_step) begin
        w_lamp = r_bcnt[0] ? '0 : '1;
        w_bcnt = r_bcnt + BW'(1);
        if (r_bcnt == B_LAST) w_fin = 1'b1;
      end
      default: w_state = IDLE;
    endcase

    if (w_fin) begin
      w_state = IDLE;
      w_idx   = '0;
      w_busy  = 1'b0;
      w_done  = 1'b1;
      w_lamp  = '0;
    end
  end

  assign bus.lamp = r_lamp;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_bound_flash_multi.sv
// Randomized bench for bound_flash_multi against a lamp-sequence model
// built from the fill/clear segment rules.
module tb_bound_flash_multi;
  localparam int NL = 16;
  localparam int B1 = 5;
  localparam int B2 = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          fl [3];
  logic          mi [3];
  logic [NL-1:0] lp [3];
  logic          bz [3];
  logic          dn [3];

  int n_chk = 0;
  int n_err = 0;

  logic [NL-1:0] mq [$];
  int            upq [$];
  logic [NL-1:0] ml;

  always #5 clk = ~clk;

  bound_flash_multi_if #(.N(NL)) bif0 ();
  bound_flash_multi_if #(.N(NL)) bif1 ();
  bound_flash_multi_if #(.N(NL)) bif2 ();

  assign bif0.flick  = fl[0];
  assign bif0.mirror = mi[0];
  assign lp[0] = bif0.lamp;
  assign bz[0] = bif0.busy;
  assign dn[0] = bif0.done;
  assign bif1.flick  = fl[1];
  assign bif1.mirror = mi[1];
  assign lp[1] = bif1.lamp;
  assign bz[1] = bif1.busy;
  assign dn[1] = bif1.done;
  assign bif2.flick  = fl[2];
  assign bif2.mirror = mi[2];
  assign lp[2] = bif2.lamp;
  assign bz[2] = bif2.busy;
  assign dn[2] = bif2.done;

  bound_flash_multi #(
    .N(NL), .B1(B1), .B2(B2), .DIV(1), .BLINKS(1)
  ) d0 (.clk(clk), .rst(rst), .bus(bif0));

  bound_flash_multi #(
    .N(NL), .B1(B1), .B2(B2), .DIV(4), .BLINKS(1)
  ) d1 (.clk(clk), .rst(rst), .bus(bif1));

  bound_flash_multi #(
    .N(NL), .B1(B1), .B2(B2), .DIV(1), .BLINKS(0)
  ) d2 (.clk(clk), .rst(rst), .bus(bif2));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic seg(input bit mir, input int a, input int b,
                     input bit up);
    int len;
    len = (a > b) ? a - b : b - a;
    for (int j = 0; j <= len; j++) begin
      int i;
      int p;
      i = (b >= a) ? a + j : a - j;
      p = mir ? NL - 1 - i : i;
      ml[p] = up;
      mq.push_back(ml);
    end
  endtask

  // Lamp value after every step of a whole run, plus UP2-end step numbers.
  task automatic build(input bit mir, input int kicks, input int blinks);
    mq.delete();
    upq.delete();
    ml = '0;
    seg(mir, 0, B1, 1);
    seg(mir, B1, 0, 0);
    seg(mir, 0, B2, 1);
    upq.push_back(mq.size());
    repeat (kicks) begin
      seg(mir, B2, 0, 0);
      seg(mir, 0, B2, 1);
      upq.push_back(mq.size());
    end
    seg(mir, B2, B1, 0);
    seg(mir, B1, NL - 1, 1);
    seg(mir, NL - 1, 0, 0);
    repeat (blinks) begin
      mq.push_back('1);
      mq.push_back('0);
    end
  endtask

  task automatic run(input int k, input int div, input int blinks,
                     input bit mir, input int kicks, input bit hold,
                     input bit abort);
    int total;
    int abort_at;
    logic [NL-1:0] cur;
    bit f;
    bit last;
    build(mir, kicks, blinks);
    total    = mq.size();
    abort_at = abort ? upq[kicks] + 3 : -1;
    chk($sformatf("pre_lamp k%0d", k), lp[k], 0);
    chk($sformatf("pre_busy k%0d", k), bz[k], 0);
    @(negedge clk);
    fl[k] = 1'b1;
    mi[k] = mir;
    @(posedge clk);
    #1;
    chk($sformatf("start_busy k%0d", k), bz[k], 1);
    chk($sformatf("start_lamp k%0d", k), lp[k], 0);
    chk($sformatf("start_done k%0d", k), dn[k], 0);
    cur = '0;
    for (int s = 1; s <= total; s++) begin
      for (int c = 1; c <= div; c++) begin
        @(negedge clk);
        mi[k] = bit'($urandom_range(0, 1));
        f = bit'($urandom_range(0, 1));
        for (int j = 0; j <= kicks; j++)
          if (s == upq[j]) f = (j < kicks);
        if (hold && s > upq[kicks]) f = 1'b1;
        fl[k] = f;
        @(posedge clk);
        #1;
        last = (s == total) && (c == div);
        if (c == div) cur = mq[s-1];
        chk($sformatf("lamp k%0d s%0d c%0d", k, s, c), lp[k], cur);
        chk($sformatf("busy k%0d s%0d c%0d", k, s, c), bz[k], !last);
        chk($sformatf("done k%0d s%0d c%0d", k, s, c), dn[k], last);
        if (s == abort_at && c == div) begin
          #2 rst = 1'b1;
          #1;
          chk("abort_lamp", lp[k], 0);
          chk("abort_busy", bz[k], 0);
          chk("abort_done", dn[k], 0);
          @(negedge clk);
          rst   = 1'b0;
          fl[k] = 1'b0;
          @(posedge clk);
          #1;
          chk("abort_after_done", dn[k], 0);
          chk("abort_after_busy", bz[k], 0);
          return;
        end
      end
    end
    @(negedge clk);
    fl[k] = hold;
    @(posedge clk);
    #1;
    chk($sformatf("post_done k%0d", k), dn[k], 0);
    chk($sformatf("post_lamp k%0d", k), lp[k], 0);
    chk($sformatf("post_busy k%0d", k), bz[k], hold);
    if (hold) begin
      @(negedge clk);
      fl[k] = 1'b0;
      rst   = 1'b1;
      #1;
      chk("hold_rst_busy", bz[k], 0);
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    int gap;
    int km;
    int mr;
    for (int k = 0; k < 3; k++) begin
      fl[k] = 1'b0;
      mi[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_lamp k%0d", k), lp[k], 0);
      chk($sformatf("rst_busy k%0d", k), bz[k], 0);
      chk($sformatf("rst_done k%0d", k), dn[k], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    run(0, 1, 1, 1'b0, 0, 1'b0, 1'b0);
    run(0, 1, 1, 1'b0, 1, 1'b0, 1'b0);
    run(0, 1, 1, 1'b1, 0, 1'b0, 1'b0);
    repeat (6) begin
      gap = int'($urandom_range(0, 3));
      km  = int'($urandom_range(0, 2));
      mr  = int'($urandom_range(0, 1));
      repeat (gap) @(negedge clk);
      run(0, 1, 1, mr[0], km, 1'b0, 1'b0);
    end
    run(0, 1, 1, 1'b0, 0, 1'b0, 1'b1);
    run(0, 1, 1, 1'b0, 0, 1'b0, 1'b0);

    run(1, 4, 1, 1'b0, 0, 1'b0, 1'b0);
    run(1, 4, 1, 1'b1, 1, 1'b0, 1'b0);

    run(2, 1, 0, 1'b0, 0, 1'b1, 1'b0);
    run(2, 1, 0, 1'b1, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
